vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display fetches own every fourth beam slot, CPU writes drain a small FIFO in the remaining slots.
// Optional rejected-request counter enabled with `define VRAM_OVF_CNT_EN.
module vram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int WORDS_PER_LINE = 160,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              blank_b,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_full,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [15:0]       ovf_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state, next_state;
  wr_req_t           fifo [FIFO_DEPTH];
  wr_req_t           head;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    count, count_nxt;
  logic              fetch_slot, push, pop;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        vld_pipe;

  assign fetch_slot = blank_b && (hcnt[1:0] == 2'b00);
  // Line base plus word column, formed at 32 bits before truncation.
  assign fetch_addr = ADDR_W'(32'(vcnt) * 32'(WORDS_PER_LINE) + 32'(hcnt[9:2]));
  assign cpu_ack    = cpu_req && !cpu_full;
  assign push       = cpu_ack;
  assign pop        = (next_state == WRITE);
  assign head       = fifo[rptr];

  always_comb begin
    next_state = IDLE;
    if (fetch_slot)        next_state = FETCH;
    else if (count != '0)  next_state = WRITE;
  end

  always_ff @(posedge vgaclk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next_state;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge vgaclk)
    if (push) fifo[wptr] <= '{addr: cpu_addr, data: cpu_wdata};

  always_ff @(posedge vgaclk or posedge reset)
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      cpu_full <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count_nxt;
      cpu_full <= (count_nxt == (PTR_W+1)'(FIFO_DEPTH));
    end

  // RAM port is registered on the slot decision; IDLE holds address/data.
  always_ff @(posedge vgaclk or posedge reset)
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (next_state)
        FETCH: begin
          mem_we   <= 1'b0;
          mem_addr <= fetch_addr;
        end
        WRITE: begin
          mem_we    <= 1'b1;
          mem_addr  <= head.addr;
          mem_wdata <= head.data;
        end
        default: mem_we <= 1'b0;
      endcase
    end

  // vld_pipe[0]: RAM read data arrives this cycle; vld_pipe[1]: pixel word loaded.
  always_ff @(posedge vgaclk or posedge reset)
    if (reset) begin
      vld_pipe <= '0;
      pix_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], state == FETCH};
      if (vld_pipe[0]) pix_data <= mem_rdata;
    end

  assign pix_valid = vld_pipe[1];

`ifdef VRAM_OVF_CNT_EN
  logic [15:0] ovf_q;
  always_ff @(posedge vgaclk or posedge reset)
    if (reset)                                       ovf_q <= '0;
    else if (cpu_req && !cpu_ack && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: fetch-address vector table, CPU write scoreboard, and corner-case sequences.
module tb_vram_arbiter;
  localparam int ADDR_W = 16, DATA_W = 8, WPL = 160, DEPTH = 4;

  logic              vgaclk = 0, reset = 0, blank_b = 0, cpu_req = 0;
  logic [9:0]        hcnt = 0, vcnt = 0;
  logic [ADDR_W-1:0] cpu_addr = 0, mem_addr;
  logic [DATA_W-1:0] cpu_wdata = 0, mem_wdata, mem_rdata = 0, pix_data;
  logic              cpu_ack, cpu_full, mem_we, pix_valid;
  logic [15:0]       ovf_cnt;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .FIFO_DEPTH(DEPTH)) dut (
    .vgaclk(vgaclk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt), .blank_b(blank_b),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_full(cpu_full), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid), .ovf_cnt(ovf_cnt));

  always #5 vgaclk = ~vgaclk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: model predicts each edge just before it happens and checks the previous one.
  typedef struct {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
  wr_t         q[$];
  int          exp_cnt = 0, wr_seen = 0;
  logic        exp_we = 0;
  logic [15:0] exp_ovf = 0;

  always @(negedge vgaclk) begin
    #3;
    if (reset) begin
      q.delete();
      exp_cnt = 0;
      exp_we  = 0;
      exp_ovf = 0;
    end else begin
      logic slot, push, pop;
      wr_t  w;
      chk("mem_we", mem_we, exp_we);
      if (mem_we) begin
        wr_seen++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_write actual_addr=%0h expected=no_write", mem_addr);
        end else begin
          w = q.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
        end
      end
      chk("cpu_full", cpu_full, exp_cnt == DEPTH);
      chk("cpu_ack", cpu_ack, cpu_req && exp_cnt < DEPTH);
      chk("ovf_cnt", ovf_cnt, exp_ovf);
      slot = blank_b && hcnt[1:0] == 2'b00;
      pop  = !slot && exp_cnt > 0;
      push = cpu_req && exp_cnt < DEPTH;
      if (push) q.push_back('{a: cpu_addr, d: cpu_wdata});
      exp_cnt = exp_cnt + int'(push) - int'(pop);
      exp_we  = pop;
`ifdef VRAM_OVF_CNT_EN
      if (cpu_req && !push && exp_ovf != 16'hFFFF) exp_ovf++;
`endif
    end
  end

  typedef struct {
    logic [9:0]        v;
    logic [9:0]        h;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] addr;
  } fvec_t;
  fvec_t fv [5];

  task automatic reset_outputs(input string tag);
    chk({tag, "_mem_we"},    mem_we, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_pix_data"},  pix_data, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_cpu_full"},  cpu_full, 0);
    chk({tag, "_ovf_cnt"},   ovf_cnt, 0);
  endtask

  task automatic push_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge vgaclk);
    cpu_req = 1; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    int ws;
    logic [15:0] ovf_exp;
    fv[0] = '{10'd2,   10'd8,   8'hA5, 16'd322};
    fv[1] = '{10'd0,   10'd0,   8'h3C, 16'd0};
    fv[2] = '{10'd1,   10'd4,   8'h5A, 16'd161};
    fv[3] = '{10'd100, 10'd320, 8'h81, 16'd16080};
    fv[4] = '{10'd479, 10'd636, 8'hFF, 16'd11263}; // 76799 truncated to 16 bits

    #1 reset = 1;
    #1 reset_outputs("rst");
    repeat (2) @(negedge vgaclk);
    reset = 0;

    // Display fetch: address on the RAM port one edge later, pixel two edges later.
    for (int i = 0; i < 5; i++) begin
      @(negedge vgaclk);
      blank_b = 1; vcnt = fv[i].v; hcnt = fv[i].h; mem_rdata = fv[i].rd;
      @(negedge vgaclk);
      chk("fetch_addr", mem_addr, fv[i].addr);
      chk("fetch_we", mem_we, 0);
      hcnt = fv[i].h + 10'd1;
      @(negedge vgaclk);
      chk("pix_valid_early", pix_valid, 0);
      @(negedge vgaclk);
      chk("pix_valid", pix_valid, 1);
      chk("pix_data", pix_data, fv[i].rd);
    end

    // Two writes during blanking land back to back in order.
    @(negedge vgaclk);
    blank_b = 0; ws = wr_seen;
    push_req(16'h0010, 8'h11);
    push_req(16'h0011, 8'h22);
    @(negedge vgaclk) cpu_req = 0;
    repeat (4) @(negedge vgaclk);
    chk("blank_writes", wr_seen - ws, 2);
    chk("blank_empty_full", cpu_full, 0);

    // Active line: a pending write must avoid the fetch slots.
    ws = wr_seen;
    @(negedge vgaclk);
    blank_b = 1; hcnt = 0;
    push_req(16'h1234, 8'h77);
    for (int h = 1; h < 8; h++) begin
      @(negedge vgaclk);
      cpu_req = 0; hcnt = 10'(h);
    end
    repeat (2) @(negedge vgaclk);
    chk("active_writes", wr_seen - ws, 1);

    // Back-to-back requests with every slot a fetch: FIFO fills, excess rejected.
    @(negedge vgaclk);
    hcnt = 0; ws = wr_seen;
    for (int i = 0; i < 6; i++) begin
      push_req(16'h0200 + 16'(i), 8'hC0 + 8'(i));
      #1 chk("fill_ack", cpu_ack, i < DEPTH);
    end
    @(negedge vgaclk) cpu_req = 0;
    #1;
    chk("fill_full", cpu_full, 1);
`ifdef VRAM_OVF_CNT_EN
    ovf_exp = 16'd2;
`else
    ovf_exp = 16'd0;
`endif
    chk("fill_ovf", ovf_cnt, ovf_exp);
    @(negedge vgaclk) blank_b = 0;
    repeat (8) @(negedge vgaclk);
    chk("drain_writes", wr_seen - ws, DEPTH);
    chk("drain_full", cpu_full, 0);

    // Reset with three entries queued and a fetch in flight discards all of it.
    @(negedge vgaclk);
    blank_b = 1; hcnt = 0; mem_rdata = 8'h99;
    push_req(16'h0300, 8'h01);
    push_req(16'h0301, 8'h02);
    push_req(16'h0302, 8'h03);
    @(negedge vgaclk) cpu_req = 0;
    @(negedge vgaclk) reset = 1;
    #1 reset_outputs("midrst");
    @(negedge vgaclk);
    reset = 0; blank_b = 0; ws = wr_seen;
    repeat (10) @(negedge vgaclk);
    chk("post_reset_writes", wr_seen - ws, 0);
    chk("post_reset_pix_valid", pix_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
